// File: rtl/delay_timer_us.sv
// Programmable microsecond delay/interval timer: exact 1us prescaler feeding a
// runtime-loaded countdown, with one-shot/periodic modes, abort and optional retrigger.
module delay_timer_us #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int DELAY_W     = 16,
  parameter bit RETRIGGER   = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               periodic,
  input  logic [DELAY_W-1:0] delay_us,
  output logic               busy,
  output logic               done,
  output logic [DELAY_W-1:0] remaining_us
);

  localparam int CYCLES_PER_US = CLK_FREQ_HZ / 1_000_000;
  localparam int PRESC_W       = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CYCLES_PER_US - 1);
  localparam logic [PRESC_W-1:0] PRESC_ZERO = {PRESC_W{1'b0}};
  localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
  localparam logic [DELAY_W-1:0] DLY_ZERO   = {DELAY_W{1'b0}};
  localparam logic [DELAY_W-1:0] DLY_ONE    = DELAY_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r, state_nx_s;
  logic [PRESC_W-1:0] presc_r, presc_nx_s;
  logic [DELAY_W-1:0] rem_r, rem_nx_s;
  logic [DELAY_W-1:0] n_r, n_nx_s;
  logic               mode_r, mode_nx_s;
  logic               busy_r;
  logic               done_r, done_nx_s;
  logic               accept_s;
  logic               wrap_s;

  // Next-state logic: abort beats start, start (when accepted) beats the countdown.
  always_comb begin
    state_nx_s = state_r;
    presc_nx_s = presc_r;
    rem_nx_s   = rem_r;
    n_nx_s     = n_r;
    mode_nx_s  = mode_r;
    done_nx_s  = 1'b0;
    accept_s   = start & ~abort & ((state_r == ST_IDLE) | (RETRIGGER == 1'b1));
    wrap_s     = (state_r == ST_RUN) && (presc_r == PRESC_LAST);

    if ((state_r == ST_RUN) && abort) begin
      state_nx_s = ST_IDLE;
      presc_nx_s = PRESC_ZERO;
      rem_nx_s   = DLY_ZERO;
    end else if (accept_s) begin
      if (delay_us == DLY_ZERO) begin
        // A zero delay expires immediately and never enters RUN.
        done_nx_s  = 1'b1;
        state_nx_s = ST_IDLE;
        presc_nx_s = PRESC_ZERO;
        rem_nx_s   = DLY_ZERO;
      end else begin
        state_nx_s = ST_RUN;
        presc_nx_s = PRESC_ZERO;
        rem_nx_s   = delay_us;
        n_nx_s     = delay_us;
        mode_nx_s  = periodic;
      end
    end else begin
      case (state_r)
        ST_RUN: begin
          if (wrap_s) begin
            presc_nx_s = PRESC_ZERO;
            if (rem_r == DLY_ONE) begin
              done_nx_s = 1'b1;
              if (mode_r) begin
                rem_nx_s = n_r;
              end else begin
                rem_nx_s   = DLY_ZERO;
                state_nx_s = ST_IDLE;
              end
            end else begin
              rem_nx_s = rem_r - DLY_ONE;
            end
          end else begin
            presc_nx_s = presc_r + PRESC_ONE;
          end
        end
        ST_IDLE: begin
          state_nx_s = ST_IDLE;
        end
        default: begin
          state_nx_s = ST_IDLE;
          presc_nx_s = PRESC_ZERO;
          rem_nx_s   = DLY_ZERO;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      presc_r <= PRESC_ZERO;
      rem_r   <= DLY_ZERO;
      n_r     <= DLY_ZERO;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      presc_r <= presc_nx_s;
      rem_r   <= rem_nx_s;
      n_r     <= n_nx_s;
      mode_r  <= mode_nx_s;
      busy_r  <= (state_nx_s == ST_RUN);
      done_r  <= done_nx_s;
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign remaining_us = rem_r;

endmodule

// File: tb/tb_delay_timer_us.sv
// Bench for delay_timer_us: three instances (50 MHz no-retrigger, 50 MHz retrigger,
// 2 MHz no-retrigger) share inputs and are compared every cycle against a cycle-countdown model.
module tb_delay_timer_us;

  logic        clk = 1'b0;
  logic        reset, start, abort, periodic;
  logic [15:0] delay_us;
  logic [2:0]  busy_v, done_v;
  logic [15:0] rem_v [3];

  int checks = 0;
  int errors = 0;

  // Model state: cycles left until the next expiry edge, plus latched delay/mode.
  int m_t    [3];
  int m_n    [3];
  bit m_busy [3];
  bit m_done [3];
  bit m_per  [3];

  always #5 clk = ~clk;

  delay_timer_us #(.CLK_FREQ_HZ(50_000_000), .DELAY_W(16), .RETRIGGER(1'b0)) u_r0 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .periodic(periodic),
    .delay_us(delay_us), .busy(busy_v[0]), .done(done_v[0]), .remaining_us(rem_v[0]));

  delay_timer_us #(.CLK_FREQ_HZ(50_000_000), .DELAY_W(16), .RETRIGGER(1'b1)) u_r1 (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .periodic(periodic),
    .delay_us(delay_us), .busy(busy_v[1]), .done(done_v[1]), .remaining_us(rem_v[1]));

  delay_timer_us #(.CLK_FREQ_HZ(2_000_000), .DELAY_W(16), .RETRIGGER(1'b0)) u_fast (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .periodic(periodic),
    .delay_us(delay_us), .busy(busy_v[2]), .done(done_v[2]), .remaining_us(rem_v[2]));

  function automatic int cpu_of(input int i);
    return (i == 2) ? 2 : 50;
  endfunction

  function automatic bit rt_of(input int i);
    return (i == 1);
  endfunction

  task automatic check_value(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input int i);
    int c;
    c = cpu_of(i);
    m_done[i] = 1'b0;
    if (reset) begin
      m_busy[i] = 1'b0; m_t[i] = 0; m_n[i] = 0; m_per[i] = 1'b0;
    end else if (abort) begin
      if (m_busy[i]) begin
        m_busy[i] = 1'b0; m_t[i] = 0;
      end
    end else if (start && (!m_busy[i] || rt_of(i))) begin
      if (delay_us == 16'd0) begin
        m_done[i] = 1'b1; m_busy[i] = 1'b0; m_t[i] = 0;
      end else begin
        m_busy[i] = 1'b1; m_n[i] = int'(delay_us); m_per[i] = periodic; m_t[i] = m_n[i] * c;
      end
    end else if (m_busy[i]) begin
      m_t[i]--;
      if (m_t[i] == 0) begin
        m_done[i] = 1'b1;
        if (m_per[i]) m_t[i] = m_n[i] * c;
        else m_busy[i] = 1'b0;
      end
    end
  endtask

  // Every cycle: advance the model on the edge, compare all outputs just after it.
  always begin
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    #1;
    for (int i = 0; i < 3; i++) begin
      int c;
      int rem_exp;
      c = cpu_of(i);
      rem_exp = m_busy[i] ? (m_t[i] + c - 1) / c : 0;
      check_value($sformatf("busy%0d", i), longint'(busy_v[i]), longint'(m_busy[i]));
      check_value($sformatf("done%0d", i), longint'(done_v[i]), longint'(m_done[i]));
      check_value($sformatf("rem%0d", i), longint'(rem_v[i]), longint'(rem_exp));
    end
  end

  task automatic wait_done(input int idx, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!done_v[idx] && n < limit);
  endtask

  task automatic count_done(input int idx, input int cycles, output int cnt);
    cnt = 0;
    repeat (cycles) begin
      @(posedge clk);
      #2;
      if (done_v[idx]) cnt++;
    end
  endtask

  task automatic launch(input logic per, input logic [15:0] d);
    @(negedge clk);
    start = 1'b1; periodic = per; delay_us = d;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    int first0, first1, cnt0, cnt1;
    reset = 1'b1; start = 1'b0; abort = 1'b0; periodic = 1'b0; delay_us = 16'd0;
    repeat (3) @(posedge clk);
    #2;
    check_value("reset_busy", longint'(busy_v), 0);
    check_value("reset_done", longint'(done_v), 0);
    check_value("reset_rem", longint'(rem_v[0]), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // One-shot of 3us.
    launch(1'b0, 16'd3);
    check_value("t1_busy_k1", longint'(busy_v[0]), 1);
    check_value("t1_rem_k1", longint'(rem_v[0]), 3);
    wait_done(0, 1000, n);
    check_value("t1_latency", n, 150);
    check_value("t1_busy_at_done", longint'(busy_v[0]), 0);
    @(posedge clk);
    #2;
    check_value("t1_single_pulse", longint'(done_v[0]), 0);

    // Periodic 2us, then abort.
    launch(1'b1, 16'd2);
    wait_done(0, 1000, n);
    check_value("t2_period1", n, 100);
    wait_done(0, 1000, n);
    check_value("t2_period2", n, 100);
    check_value("t2_busy_held", longint'(busy_v[0]), 1);
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    count_done(0, 400, cnt);
    check_value("t2_no_done_after_abort", cnt, 0);
    check_value("t2_busy_after_abort", longint'(busy_v[0]), 0);

    // Abort coincident with the expiring wrap of a 1us delay.
    launch(1'b0, 16'd1);
    repeat (49) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check_value("t3_done_suppressed", longint'(done_v[0]), 0);
    check_value("t3_busy_cleared", longint'(busy_v[0]), 0);
    count_done(0, 100, cnt);
    check_value("t3_no_late_done", cnt, 0);

    // Start while busy: 4us at k, 1us at k+120.
    launch(1'b0, 16'd4);
    repeat (119) @(posedge clk);
    #1;
    start = 1'b1; delay_us = 16'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    first0 = -1; first1 = -1; cnt0 = 0; cnt1 = 0;
    for (int j = 121; j <= 260; j++) begin
      @(posedge clk);
      #2;
      if (done_v[0]) begin cnt0++; if (first0 < 0) first0 = j; end
      if (done_v[1]) begin cnt1++; if (first1 < 0) first1 = j; end
    end
    check_value("t4_retrig_latency", first1, 170);
    check_value("t4_retrig_count", cnt1, 1);
    check_value("t4_noretrig_latency", first0, 200);
    check_value("t4_noretrig_count", cnt0, 1);

    // Zero delay and wide delays.
    launch(1'b0, 16'd0);
    check_value("t5_zero_done", longint'(done_v[0]), 1);
    check_value("t5_zero_busy", longint'(busy_v[0]), 0);
    @(posedge clk);
    #2;
    check_value("t5_zero_single", longint'(done_v[0]), 0);
    @(negedge clk);
    start = 1'b1; delay_us = 16'd0;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    launch(1'b0, 16'h8001);
    check_value("t5_fast_load", longint'(rem_v[2]), 16'h8001);
    repeat (2) @(posedge clk);
    #2;
    check_value("t5_fast_8000", longint'(rem_v[2]), 16'h8000);
    repeat (2) @(posedge clk);
    #2;
    check_value("t5_fast_7fff", longint'(rem_v[2]), 16'h7FFF);
    check_value("t5_slow_8001", longint'(rem_v[0]), 16'h8001);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    launch(1'b0, 16'hFFFF);
    check_value("t5_ffff_load", longint'(rem_v[2]), 16'hFFFF);
    repeat (2) @(posedge clk);
    #2;
    check_value("t5_ffff_dec", longint'(rem_v[2]), 16'hFFFE);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;

    // Reset in the middle of a 5us delay, with start held during reset.
    launch(1'b0, 16'd5);
    repeat (74) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1; delay_us = 16'd3;
    @(posedge clk);
    #2;
    check_value("t6_busy", longint'(busy_v[0]), 0);
    check_value("t6_done", longint'(done_v[0]), 0);
    check_value("t6_rem", longint'(rem_v[0]), 0);
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    #2;
    check_value("t6_start_ignored", longint'(busy_v[0]), 0);
    count_done(0, 300, cnt);
    check_value("t6_no_done", cnt, 0);

    // Randomized traffic; the per-cycle monitor does the checking.
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      reset    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 29) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      periodic = 1'($urandom_range(0, 1));
      delay_us = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
